// File: rtl/alu_cmd_fifo.sv
// Command FIFO in front of the registered 4-bit ALU: buffers {A, B, opcode}, issues one
// command per clock onto registered ALU inputs and flags the cycle each result appears.
module alu_cmd_fifo #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2,
    parameter int LAT    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_A,
    input  logic [3:0]        in_B,
    input  logic [1:0]        in_opcode,
    input  logic              issue_en,
    output logic [3:0]        alu_A,
    output logic [3:0]        alu_B,
    output logic [1:0]        alu_opcode,
    output logic              issue,
    output logic              res_valid,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty
);

    localparam int              ENTRY_W  = 10;
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]  wr_ptr;
    logic [ADDR_W-1:0]  rd_ptr;
    logic [ADDR_W:0]    count_nxt;
    logic [ENTRY_W-1:0] rd_entry;
    logic [LAT-1:0]     vld_p;
    logic               push;
    logic               pop;

    // Push is gated by the registered full flag, so a full FIFO refuses a write even
    // when a pop happens on the same edge.
    assign in_ready = !full;
    assign push     = in_valid & ~full;
    assign pop      = issue_en & ~empty;
    assign rd_entry = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    // Storage stage: entries carry data only, so they are not reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_A, in_B, in_opcode};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_nxt;
            full  <= (count_nxt == FULL_CNT);
            empty <= (count_nxt == '0);
        end
    end

    // Issue stage: ALU operands hold their value between pops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_A      <= '0;
            alu_B      <= '0;
            alu_opcode <= '0;
            issue      <= 1'b0;
        end else begin
            issue <= pop;
            if (pop) begin
                alu_A      <= rd_entry[9:6];
                alu_B      <= rd_entry[5:2];
                alu_opcode <= rd_entry[1:0];
            end
        end
    end

    // Result-tracking stage: one valid bit per ALU register stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p <= '0;
        end else begin
            vld_p[0] <= issue;
            for (int i = 1; i < LAT; i++) begin
                vld_p[i] <= vld_p[i-1];
            end
        end
    end

    assign res_valid = vld_p[LAT-1];

endmodule

// File: tb/tb_alu_cmd_fifo.sv
// Scoreboard bench for alu_cmd_fifo: commands queued at push time, compared in order at issue.
module tb_alu_cmd_fifo;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;
    localparam int LAT    = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_A;
    logic [3:0]        in_B;
    logic [1:0]        in_opcode;
    logic              issue_en;
    logic [3:0]        alu_A;
    logic [3:0]        alu_B;
    logic [1:0]        alu_opcode;
    logic              issue;
    logic              res_valid;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              empty;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [9:0]  exp_q[$];
    logic [9:0]  exp_cmd;
    wire  [9:0]  got = {alu_A, alu_B, alu_opcode};

    alu_cmd_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .LAT(LAT)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_A(in_A), .in_B(in_B), .in_opcode(in_opcode), .issue_en(issue_en),
        .alu_A(alu_A), .alu_B(alu_B), .alu_opcode(alu_opcode), .issue(issue),
        .res_valid(res_valid), .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [9:0] c);
        in_valid  = v;
        in_A      = c[9:6];
        in_B      = c[5:2];
        in_opcode = c[1:0];
    endtask

    task automatic test_reset;
        issue_en = 1'b1;
        drive(1'b1, {4'd7, 4'd9, 2'b10});
        tick;
        drive(1'b1, {4'd4, 4'd6, 2'b11});
        tick;
        drive(1'b0, 10'd0);
        issue_en = 1'b0;
        n_checks++;
        if (issue !== 1'b1 || count !== 3'd1 || got !== {4'd7, 4'd9, 2'b10}) begin
            n_fail++;
            $display("FAIL reset_pre: issue=%b count=%0d alu=%h, required issue=1 count=1 alu=%h",
                     issue, count, got, {4'd7, 4'd9, 2'b10});
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (count !== 3'd0 || empty !== 1'b1 || full !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_flags: count=%0d empty=%b full=%b in_ready=%b, required 0 1 0 1",
                     count, empty, full, in_ready);
        end
        n_checks++;
        if (issue !== 1'b0 || res_valid !== 1'b0 || got !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: issue=%b res_valid=%b alu=%h, required 0 0 000",
                     issue, res_valid, got);
        end
        tick;
        rst = 1'b0;
        tick;
        n_checks++;
        if (issue !== 1'b0 || count !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_release: issue=%b count=%0d, required 0 0", issue, count);
        end
    endtask

    task automatic test_single;
        issue_en = 1'b1;
        drive(1'b1, {4'd3, 4'd5, 2'b01});
        exp_q.push_back({4'd3, 4'd5, 2'b01});
        tick;
        drive(1'b0, 10'd0);
        n_checks++;
        if (count !== 3'd1 || issue !== 1'b0) begin
            n_fail++;
            $display("FAIL single_push: count=%0d issue=%b, required 1 0", count, issue);
        end
        tick;
        n_checks++;
        if (issue !== 1'b1 || exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL single_issue: issue=%b, required 1", issue);
        end else begin
            exp_cmd = exp_q.pop_front();
            if (got !== exp_cmd) begin
                n_fail++;
                $display("FAIL single_cmd: alu=%h, required %h", got, exp_cmd);
            end
        end
        n_checks++;
        if (empty !== 1'b1 || res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_empty: empty=%b res_valid=%b, required 1 0", empty, res_valid);
        end
        for (int c = 1; c <= 3; c++) begin
            tick;
            n_checks++;
            if (res_valid !== (c == LAT) || issue !== 1'b0) begin
                n_fail++;
                $display("FAIL single_res c=%0d: res_valid=%b issue=%b, required %b 0",
                         c, res_valid, issue, (c == LAT));
            end
        end
    endtask

    task automatic test_fill;
        issue_en = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, {4'(i), 4'(15 - i), 2'(i)});
            n_checks++;
            if (in_ready !== (i <= DEPTH)) begin
                n_fail++;
                $display("FAIL fill_ready i=%0d: in_ready=%b, required %b", i, in_ready, (i <= DEPTH));
            end
            if (i <= DEPTH) exp_q.push_back({4'(i), 4'(15 - i), 2'(i)});
            tick;
        end
        drive(1'b0, 10'd0);
        n_checks++;
        if (full !== 1'b1 || in_ready !== 1'b0 || count !== 3'd4 || issue !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_full: full=%b in_ready=%b count=%0d issue=%b, required 1 0 4 0",
                     full, in_ready, count, issue);
        end
        issue_en = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick;
            n_checks++;
            if (issue !== (c < 4)) begin
                n_fail++;
                $display("FAIL fill_issue c=%0d: issue=%b, required %b", c, issue, (c < 4));
            end else if (issue) begin
                exp_cmd = exp_q.pop_front();
                if (got !== exp_cmd) begin
                    n_fail++;
                    $display("FAIL fill_order c=%0d: alu=%h, required %h", c, got, exp_cmd);
                end
            end
            n_checks++;
            if (res_valid !== (c >= 2 && c < 6)) begin
                n_fail++;
                $display("FAIL fill_res c=%0d: res_valid=%b, required %b", c, res_valid, (c >= 2 && c < 6));
            end
            if (c == 3) begin
                n_checks++;
                if (empty !== 1'b1 || count !== 3'd0) begin
                    n_fail++;
                    $display("FAIL fill_empty: empty=%b count=%0d, required 1 0", empty, count);
                end
            end
        end
        issue_en = 1'b0;
    endtask

    task automatic test_wrap;
        logic [9:0] c;
        issue_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            c = 10'($urandom_range(0, 1023));
            drive(1'b1, c);
            exp_q.push_back(c);
            tick;
        end
        issue_en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            c = 10'($urandom_range(0, 1023));
            drive(1'b1, c);
            exp_q.push_back(c);
            tick;
            n_checks++;
            if (count !== 3'd2) begin
                n_fail++;
                $display("FAIL wrap_count k=%0d: count=%0d, required 2", k, count);
            end
            n_checks++;
            if (issue !== 1'b1) begin
                n_fail++;
                $display("FAIL wrap_issue k=%0d: issue=%b, required 1", k, issue);
            end else begin
                exp_cmd = exp_q.pop_front();
                if (got !== exp_cmd) begin
                    n_fail++;
                    $display("FAIL wrap_order k=%0d: alu=%h, required %h", k, got, exp_cmd);
                end
            end
        end
        drive(1'b0, 10'd0);
        for (int k = 0; k < 2; k++) begin
            tick;
            n_checks++;
            if (issue !== 1'b1 || count !== 3'(1 - k)) begin
                n_fail++;
                $display("FAIL wrap_drain k=%0d: issue=%b count=%0d, required 1 %0d", k, issue, count, 1 - k);
            end else begin
                exp_cmd = exp_q.pop_front();
                if (got !== exp_cmd) begin
                    n_fail++;
                    $display("FAIL wrap_drain_order k=%0d: alu=%h, required %h", k, got, exp_cmd);
                end
            end
        end
        tick;
        n_checks++;
        if (issue !== 1'b0 || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_end: issue=%b empty=%b, required 0 1", issue, empty);
        end
        issue_en = 1'b0;
        tick;
        tick;
    endtask

    task automatic test_full_pop;
        logic [9:0] c;
        logic [9:0] x;
        issue_en = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            c = 10'($urandom_range(0, 1023));
            drive(1'b1, c);
            exp_q.push_back(c);
            tick;
        end
        x = 10'h2A5;
        drive(1'b1, x);
        issue_en = 1'b1;
        n_checks++;
        if (in_ready !== 1'b0 || full !== 1'b1) begin
            n_fail++;
            $display("FAIL fullpop_pre: in_ready=%b full=%b, required 0 1", in_ready, full);
        end
        tick;
        n_checks++;
        if (issue !== 1'b1 || count !== 3'd3 || full !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL fullpop_edge: issue=%b count=%0d full=%b in_ready=%b, required 1 3 0 1",
                     issue, count, full, in_ready);
        end else begin
            exp_cmd = exp_q.pop_front();
            if (got !== exp_cmd) begin
                n_fail++;
                $display("FAIL fullpop_cmd: alu=%h, required %h", got, exp_cmd);
            end
        end
        exp_q.push_back(x);
        tick;
        drive(1'b0, 10'd0);
        n_checks++;
        if (issue !== 1'b1 || count !== 3'd3) begin
            n_fail++;
            $display("FAIL fullpop_accept: issue=%b count=%0d, required 1 3", issue, count);
        end else begin
            exp_cmd = exp_q.pop_front();
            if (got !== exp_cmd) begin
                n_fail++;
                $display("FAIL fullpop_cmd2: alu=%h, required %h", got, exp_cmd);
            end
        end
        for (int k = 0; k < 4; k++) begin
            tick;
            n_checks++;
            if (issue !== (k < 3)) begin
                n_fail++;
                $display("FAIL fullpop_drain k=%0d: issue=%b, required %b", k, issue, (k < 3));
            end else if (issue) begin
                exp_cmd = exp_q.pop_front();
                if (got !== exp_cmd) begin
                    n_fail++;
                    $display("FAIL fullpop_drain_order k=%0d: alu=%h, required %h", k, got, exp_cmd);
                end
            end
        end
        n_checks++;
        if (empty !== 1'b1 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL fullpop_end: empty=%b pending=%0d, required 1 0", empty, exp_q.size());
        end
        issue_en = 1'b0;
        tick;
        tick;
    endtask

    task automatic test_gaps;
        logic [9:0] c;
        logic       pat [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic       exp_iss [8];
        int         remaining;
        issue_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            c = 10'($urandom_range(0, 1023));
            drive(1'b1, c);
            exp_q.push_back(c);
            tick;
        end
        drive(1'b0, 10'd0);
        remaining = 3;
        for (int i = 0; i < 8; i++) begin
            exp_iss[i] = (i < 6) && pat[i] && (remaining > 0);
            if (exp_iss[i]) remaining--;
        end
        for (int i = 0; i < 8; i++) begin
            issue_en = (i < 6) ? pat[i] : 1'b0;
            tick;
            n_checks++;
            if (issue !== exp_iss[i]) begin
                n_fail++;
                $display("FAIL gaps_issue i=%0d: issue=%b, required %b", i, issue, exp_iss[i]);
            end else if (issue) begin
                exp_cmd = exp_q.pop_front();
                if (got !== exp_cmd) begin
                    n_fail++;
                    $display("FAIL gaps_order i=%0d: alu=%h, required %h", i, got, exp_cmd);
                end
            end
            n_checks++;
            if (res_valid !== ((i >= LAT) ? exp_iss[i - LAT] : 1'b0)) begin
                n_fail++;
                $display("FAIL gaps_res i=%0d: res_valid=%b, required %b", i, res_valid,
                         (i >= LAT) ? exp_iss[i - LAT] : 1'b0);
            end
        end
        issue_en = 1'b0;
    endtask

    task automatic test_midop_reset;
        logic [9:0] c;
        issue_en = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            c = 10'($urandom_range(0, 1023));
            drive(1'b1, c);
            exp_q.push_back(c);
            tick;
        end
        drive(1'b0, 10'd0);
        issue_en = 1'b1;
        tick;
        issue_en = 1'b0;
        tick;
        tick;
        n_checks++;
        if (res_valid !== 1'b1 || count !== 3'd3) begin
            n_fail++;
            $display("FAIL midrst_pre: res_valid=%b count=%0d, required 1 3", res_valid, count);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (res_valid !== 1'b0 || count !== 3'd0 || empty !== 1'b1 || issue !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_now: res_valid=%b count=%0d empty=%b issue=%b, required 0 0 1 0",
                     res_valid, count, empty, issue);
        end
        tick;
        rst = 1'b0;
        exp_q.delete();
        issue_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick;
            n_checks++;
            if (issue !== 1'b0 || res_valid !== 1'b0 || count !== 3'd0) begin
                n_fail++;
                $display("FAIL midrst_idle k=%0d: issue=%b res_valid=%b count=%0d, required 0 0 0",
                         k, issue, res_valid, count);
            end
        end
        drive(1'b1, {4'd9, 4'd2, 2'b00});
        exp_q.push_back({4'd9, 4'd2, 2'b00});
        tick;
        drive(1'b0, 10'd0);
        tick;
        n_checks++;
        if (issue !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_new: issue=%b, required 1", issue);
        end else begin
            exp_cmd = exp_q.pop_front();
            if (got !== exp_cmd) begin
                n_fail++;
                $display("FAIL midrst_new_cmd: alu=%h, required %h", got, exp_cmd);
            end
        end
        issue_en = 1'b0;
        tick;
        tick;
        tick;
    endtask

    initial begin
        rst      = 1'b1;
        issue_en = 1'b0;
        drive(1'b0, 10'd0);
        tick;
        tick;
        rst = 1'b0;
        tick;
        test_reset();
        test_single();
        test_fill();
        test_wrap();
        test_full_pop();
        test_gaps();
        test_midop_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
